rob_alloc_ctrl: RTL



---
 rtl/rob_alloc_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: in-order tag allocation, in-order retire,
// and a youngest-first squash walk after a pipeline flush.
module rob_alloc_ctrl #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_alloc_req,
  output logic [1:0]            o_alloc_grant,
  output logic [1:0][TAG_W-1:0] o_alloc_tag,
  input  logic [1:0]            i_retire_valid,
  input  logic                  i_flush,
  output logic                  o_squash_valid,
  output logic [TAG_W-1:0]      o_squash_tag,
  output logic [TAG_W-1:0]      o_head,
  output logic [TAG_W-1:0]      o_tail,
  output logic [TAG_W:0]        o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [TAG_W:0]   DEPTH_C  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   DEPTH_M1 = (TAG_W+1)'(DEPTH - 1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t           state_reg;
  logic [TAG_W-1:0] head_reg;
  logic [TAG_W-1:0] tail_reg;
  logic [TAG_W:0]   count_reg;
  logic [TAG_W-1:0] stop_reg;
  logic [TAG_W-1:0] squash_tag_reg;
  logic             squash_valid_reg;
  logic             full_reg;
  logic             empty_reg;
  logic             busy_reg;
  logic             err_reg;

  logic             in_run;
  logic             grant_lane0;
  logic             grant_lane1;
  logic [1:0]       ret_req;
  logic [TAG_W:0]   ret_req_w;
  logic             over_retire;
  logic [TAG_W:0]   nret;
  logic [TAG_W:0]   nalloc;
  logic [TAG_W:0]   rem;
  logic [TAG_W-1:0] head_adv;
  logic [TAG_W:0]   count_next;

  // Grants depend only on registered occupancy, never on this cycle's retires.
  always_comb begin
    in_run      = (state_reg == RUN);
    grant_lane0 = in_run && !i_flush && i_alloc_req[0] && (count_reg < DEPTH_C);
    grant_lane1 = grant_lane0 && i_alloc_req[1] && (count_reg < DEPTH_M1);
  end

  assign o_alloc_grant = {grant_lane1, grant_lane0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane_tag
    assign o_alloc_tag[gi] = tail_reg + TAG_W'(gi);
  end

  // Retire is an in-order prefix; anything beyond the live count is clipped.
  always_comb begin
    ret_req     = i_retire_valid[0] ? (i_retire_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    ret_req_w   = {{(TAG_W-1){1'b0}}, ret_req};
    over_retire = in_run && (ret_req_w > count_reg);
    if (!in_run) begin
      nret = '0;
    end else if (over_retire) begin
      nret = count_reg;
    end else begin
      nret = ret_req_w;
    end
    nalloc   = {{TAG_W{1'b0}}, grant_lane0} + {{TAG_W{1'b0}}, grant_lane1};
    rem      = count_reg - nret;
    head_adv = head_reg + nret[TAG_W-1:0];
  end

  always_comb begin
    count_next = count_reg;
    if (in_run) begin
      count_next = count_reg + nalloc - nret;
    end else if (squash_tag_reg == stop_reg) begin
      count_next = '0;
    end else begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg        <= RUN;
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      stop_reg         <= '0;
      squash_tag_reg   <= '0;
      squash_valid_reg <= 1'b0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      if (over_retire) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        RUN: begin
          head_reg <= head_adv;
          if (i_flush) begin
            if (rem == '0) begin
              tail_reg <= head_adv;
            end else begin
              // Walk from the youngest live entry down to the oldest survivor.
              state_reg        <= SQUASH;
              busy_reg         <= 1'b1;
              squash_valid_reg <= 1'b1;
              squash_tag_reg   <= tail_reg - TAG_ONE;
              stop_reg         <= head_adv;
            end
          end else begin
            tail_reg <= tail_reg + nalloc[TAG_W-1:0];
          end
        end
        SQUASH: begin
          tail_reg <= squash_tag_reg;
          if (squash_tag_reg == stop_reg) begin
            state_reg        <= RUN;
            busy_reg         <= 1'b0;
            squash_valid_reg <= 1'b0;
            head_reg         <= stop_reg;
          end else begin
            squash_tag_reg <= squash_tag_reg - TAG_ONE;
          end
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign o_squash_valid = squash_valid_reg;
  assign o_squash_tag   = squash_tag_reg;
  assign o_head         = head_reg;
  assign o_tail         = tail_reg;
  assign o_count        = count_reg;
  assign o_full         = full_reg;
  assign o_empty        = empty_reg;
  assign o_busy         = busy_reg;
  assign o_err          = err_reg;

endmodule
